// File: rtl/sseg_pkg.sv
// Shared constants for seven-segment display blocks: active-low hex glyphs,
// blank pattern and PWM level count.
package sseg_pkg;

  localparam int PWM_LEVELS = 16;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Segment order {g,f,e,d,c,b,a}, active-low: 0..9, A b C d E F
  localparam logic [6:0] HEX_GLYPHS [0:15] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex_to_sseg.sv
// Combinational hex nibble to active-low seven-segment pattern {g,f,e,d,c,b,a}.
module hex_to_sseg
  import sseg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_GLYPHS[nibble];

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Time-multiplexed hex display scanner with guard subslot, 16-level PWM,
// leading-zero blanking and inputs latched once per frame.
module sseg_scan_ctrl
  import sseg_pkg::*;
#(
  parameter int N_DIGITS   = 4,
  parameter int SUB_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic                  lz_en,
  input  logic [3:0]            bright,
  output logic [N_DIGITS-1:0]   an,
  output logic [7:0]            sseg,
  output logic                  frame_tick
);

  localparam int DW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int SW = (SUB_CYCLES > 1) ? $clog2(SUB_CYCLES) : 1;

  logic [SW-1:0] sub_cnt;
  logic [3:0]    subslot;
  logic [DW-1:0] digit;

  logic sub_wrap, slot_wrap, digit_last, frame_start;

  assign sub_wrap    = (sub_cnt == SW'(SUB_CYCLES - 1));
  assign slot_wrap   = sub_wrap && (subslot == 4'(PWM_LEVELS - 1));
  assign digit_last  = (digit == DW'(N_DIGITS - 1));
  assign frame_start = (sub_cnt == '0) && (subslot == 4'd0) && (digit == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      sub_cnt <= '0;
      subslot <= '0;
      digit   <= '0;
    end else begin
      sub_cnt <= sub_wrap ? '0 : sub_cnt + 1'b1;
      if (sub_wrap)
        subslot <= subslot + 1'b1;
      if (slot_wrap)
        digit <= digit_last ? '0 : digit + 1'b1;
    end
  end

  logic [4*N_DIGITS-1:0] value_q;
  logic [N_DIGITS-1:0]   dp_q;
  logic                  lz_q;
  logic [3:0]            bright_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q  <= '0;
      dp_q     <= '0;
      lz_q     <= 1'b0;
      bright_q <= '0;
    end else if (frame_start) begin
      value_q  <= value;
      dp_q     <= dp_in;
      lz_q     <= lz_en;
      bright_q <= bright;
    end
  end

  // On the capture cycle the freshly sampled inputs drive the outputs, so the
  // first registered pattern of a frame already reflects the new snapshot.
  logic [4*N_DIGITS-1:0] value_e;
  logic [N_DIGITS-1:0]   dp_e;
  logic                  lz_e;
  logic [3:0]            bright_e;

  assign value_e  = frame_start ? value  : value_q;
  assign dp_e     = frame_start ? dp_in  : dp_q;
  assign lz_e     = frame_start ? lz_en  : lz_q;
  assign bright_e = frame_start ? bright : bright_q;

  logic [N_DIGITS-1:0] blank;
  logic                upper_zero;
  logic [3:0]          cur_nib;
  logic                cur_blank;
  logic                cur_dp;

  // Scanning from the top digit down, a digit is blanked while every nibble
  // from it upward is zero; digit 0 always shows.
  always_comb begin
    blank      = '0;
    upper_zero = 1'b1;
    cur_nib    = '0;
    cur_blank  = 1'b0;
    cur_dp     = 1'b0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero && (value_e[4*i +: 4] == 4'h0);
      blank[i]   = lz_e && (i != 0) && upper_zero;
    end
    for (int i = 0; i < N_DIGITS; i++) begin
      if (digit == DW'(i)) begin
        cur_nib   = value_e[4*i +: 4];
        cur_blank = blank[i];
        cur_dp    = dp_e[i];
      end
    end
  end

  logic [6:0] glyph;

  hex_to_sseg u_dec (
    .nibble (cur_nib),
    .seg    (glyph)
  );

  logic                anode_on;
  logic [N_DIGITS-1:0] an_next;
  logic [7:0]          sseg_next;

  // Subslot 0 is a dark guard interval between digits to avoid ghosting.
  assign anode_on  = (subslot != 4'd0) && (subslot <= bright_e);
  assign sseg_next = {~cur_dp, cur_blank ? SEG_BLANK : glyph};

  always_comb begin
    an_next = '1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (anode_on && (digit == DW'(i)))
        an_next[i] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an         <= '1;
      sseg       <= 8'hFF;
      frame_tick <= 1'b0;
    end else begin
      an         <= an_next;
      sseg       <= sseg_next;
      frame_tick <= frame_start;
    end
  end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Scoreboard bench for sseg_scan_ctrl (4 digits, 4 cycles per subslot):
// directed stimulus queues hand-computed outputs keyed by clock cycle.
module tb_sseg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        lz_en;
  logic [3:0]  bright;
  logic [3:0]  an;
  logic [7:0]  sseg;
  logic        frame_tick;

  int cyc = 0;
  int total = 0;
  int bad = 0;

  typedef struct {
    int         cyc;
    logic [3:0] an;
    logic [7:0] sseg;
    logic       tick;
    string      name;
  } exp_t;

  exp_t sb[$];

  sseg_scan_ctrl #(.N_DIGITS(4), .SUB_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .value      (value),
    .dp_in      (dp_in),
    .lz_en      (lz_en),
    .bright     (bright),
    .an         (an),
    .sseg       (sseg),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string nm, input logic [7:0] act, input logic [7:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, want);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] v, input logic [3:0] d,
                               input logic l, input logic [3:0] b);
    value  = v;
    dp_in  = d;
    lz_en  = l;
    bright = b;
  endtask

  task automatic expectAt(input int c, input logic [3:0] a, input logic [7:0] s,
                          input logic t, input string nm);
    exp_t e;
    e.cyc = c; e.an = a; e.sseg = s; e.tick = t; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic waitCyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: at each falling edge, retire every entry due for this cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        if (e.cyc < cyc) begin
          total++;
          bad++;
          $display("[TB] FAIL %s missed: cyc=%0d got=none want=cycle %0d", e.name, cyc, e.cyc);
        end else begin
          checkOutput({e.name, ".an"},   {4'h0, an},         {4'h0, e.an});
          checkOutput({e.name, ".sseg"}, sseg,               e.sseg);
          checkOutput({e.name, ".tick"}, {7'h0, frame_tick}, {7'h0, e.tick});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  localparam int F0 = 6;

  initial begin
    // Reset held for posedges 1..5; outputs must stay idle
    rst = 1'b1;
    applyStimulus(16'h1234, 4'b0100, 1'b0, 4'd15);
    for (int c = 1; c <= 5; c++) expectAt(c, 4'hF, 8'hFF, 1'b0, "reset");

    // Frame 0: scan order, full brightness
    expectAt(F0 + 0,   4'hF, 8'h99, 1'b1, "scan_d0_start");
    expectAt(F0 + 3,   4'hF, 8'h99, 1'b0, "scan_d0_guard");
    expectAt(F0 + 4,   4'hE, 8'h99, 1'b0, "scan_d0_on");
    expectAt(F0 + 63,  4'hE, 8'h99, 1'b0, "scan_d0_last");
    expectAt(F0 + 64,  4'hF, 8'hB0, 1'b0, "scan_d1_guard");
    expectAt(F0 + 68,  4'hD, 8'hB0, 1'b0, "scan_d1_on");
    expectAt(F0 + 130, 4'hF, 8'h24, 1'b0, "scan_d2_guard");
    expectAt(F0 + 132, 4'hB, 8'h24, 1'b0, "scan_d2_dp");
    expectAt(F0 + 196, 4'h7, 8'hF9, 1'b0, "scan_d3_on");
    expectAt(F0 + 256, 4'hF, 8'h99, 1'b1, "scan_tick2");
    expectAt(F0 + 257, 4'hF, 8'h99, 1'b0, "scan_tick2_end");
    waitCyc(5);
    rst = 1'b0;

    // Frame 2: bright=4, anode low for offsets 4..19 of each slot
    expectAt(518 + 3,  4'hF, 8'h99, 1'b0, "br4_guard");
    expectAt(518 + 4,  4'hE, 8'h99, 1'b0, "br4_first");
    expectAt(518 + 19, 4'hE, 8'h99, 1'b0, "br4_last");
    expectAt(518 + 20, 4'hF, 8'h99, 1'b0, "br4_off");
    expectAt(518 + 68, 4'hD, 8'hB0, 1'b0, "br4_d1_first");
    expectAt(518 + 84, 4'hF, 8'hB0, 1'b0, "br4_d1_off");
    // Frame 3: bright=0, all anodes dark
    expectAt(774 + 4,   4'hF, 8'h99, 1'b0, "br0_d0");
    expectAt(774 + 100, 4'hF, 8'hB0, 1'b0, "br0_d1");
    expectAt(774 + 200, 4'hF, 8'hF9, 1'b0, "br0_d3");
    expectAt(774 + 255, 4'hF, 8'hF9, 1'b0, "br0_end");
    waitCyc(F0 + 300);
    applyStimulus(16'h1234, 4'b0100, 1'b0, 4'd4);
    waitCyc(518 + 100);
    applyStimulus(16'h1234, 4'b0100, 1'b0, 4'd0);

    // Frame 4: 0050 with blanking; frame 5: 0000
    expectAt(1030 + 4,   4'hE, 8'hC0, 1'b0, "lz_d0");
    expectAt(1030 + 68,  4'hD, 8'h92, 1'b0, "lz_d1");
    expectAt(1030 + 132, 4'hB, 8'hFF, 1'b0, "lz_d2");
    expectAt(1030 + 196, 4'h7, 8'hFF, 1'b0, "lz_d3");
    expectAt(1286 + 4,   4'hE, 8'hC0, 1'b0, "lz0_d0");
    expectAt(1286 + 68,  4'hD, 8'hFF, 1'b0, "lz0_d1");
    expectAt(1286 + 132, 4'hB, 8'hFF, 1'b0, "lz0_d2");
    expectAt(1286 + 196, 4'h7, 8'hFF, 1'b0, "lz0_d3");
    waitCyc(774 + 100);
    applyStimulus(16'h0050, 4'b0000, 1'b1, 4'd15);
    waitCyc(1030 + 100);
    applyStimulus(16'h0000, 4'b0000, 1'b1, 4'd15);

    // Frame 6: 1111, changed to 2222 at offset 100; visible from frame 7
    expectAt(1542 + 4,   4'hE, 8'hF9, 1'b0, "latch_d0");
    expectAt(1542 + 101, 4'hD, 8'hF9, 1'b0, "latch_d1_after");
    expectAt(1542 + 132, 4'hB, 8'hF9, 1'b0, "latch_d2");
    expectAt(1542 + 255, 4'h7, 8'hF9, 1'b0, "latch_d3_end");
    expectAt(1798 + 0,   4'hF, 8'hA4, 1'b1, "latch_new_tick");
    expectAt(1798 + 4,   4'hE, 8'hA4, 1'b0, "latch_new_d0");
    expectAt(1798 + 149, 4'hB, 8'hA4, 1'b0, "pre_reset");
    // One-cycle reset at posedge 1948, fresh capture of 3333 at 1949
    expectAt(1948,      4'hF, 8'hFF, 1'b0, "midrst");
    expectAt(1949,      4'hF, 8'hB0, 1'b1, "midrst_restart");
    expectAt(1949 + 4,  4'hE, 8'hB0, 1'b0, "midrst_d0");
    expectAt(1949 + 68, 4'hD, 8'hB0, 1'b0, "midrst_d1");
    waitCyc(1286 + 100);
    applyStimulus(16'h1111, 4'b0000, 1'b0, 4'd15);
    waitCyc(1542 + 99);
    applyStimulus(16'h2222, 4'b0000, 1'b0, 4'd15);
    waitCyc(1947);
    rst = 1'b1;
    applyStimulus(16'h3333, 4'b0000, 1'b0, 4'd15);
    waitCyc(1948);
    rst = 1'b0;

    waitCyc(1949 + 80);
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    while (sb.size() > 0) begin
      total++;
      bad++;
      $display("[TB] FAIL %s pending: got=none want=cycle %0d", sb[0].name, sb[0].cyc);
      void'(sb.pop_front());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
